// File: rtl/xor_frame_checksum_pkg.sv
// rtl/xor_frame_checksum_pkg.sv - shared state encodings and defaults for the XOR frame checksum
package xor_frame_checksum_pkg;

    // Default datapath width, matching the upstream 16-bit XOR datapath.
    localparam int XOR_WIDTH = 16;

    // FSM state encodings. Plain constants keep them usable from older tools.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

endpackage

// File: rtl/xor_frame_checksum_word_fold.sv
// rtl/xor_frame_checksum_word_fold.sv - combinational WIDTH-generic bitwise XOR of two words
//
// Ports:
//   a  in  WIDTH  running accumulator
//   b  in  WIDTH  incoming word
//   f  out WIDTH  a ^ b, bit by bit (no carry between bits)
module xor_word_fold #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f
);

    genvar g;
    generate
        for (g = 0; g < WIDTH; g = g + 1) begin : g_bit
            assign f[g] = a[g] ^ b[g];
        end
    endgenerate

endmodule

// File: rtl/xor_frame_checksum.sv
// rtl/xor_frame_checksum.sv - folds a valid/ready frame of words into one XOR checksum
//
// Ports:
//   clk           in   1      single clock, posedge
//   rst           in   1      synchronous active-high reset
//   in_valid      in   1      in_data / in_last qualify this cycle
//   in_ready      out  1      block can accept a word (low only while a result is pending)
//   in_data       in   WIDTH  word folded into the checksum
//   in_last       in   1      accepted word closes the frame
//   out_valid     out  1      result available
//   out_ready     in   1      consumer takes the result
//   out_checksum  out  WIDTH  XOR of every word in the frame
//   out_count     out  CNT_W  words in the frame, saturating at MAX_WORDS
//   out_err       out  1      frame ran past MAX_WORDS
module xor_frame_checksum
    import xor_frame_checksum_pkg::*;
#(
    parameter int WIDTH     = XOR_WIDTH,
    parameter int MAX_WORDS = 256,
    parameter int CNT_W     = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_checksum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic [WIDTH-1:0] r_out_checksum;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_err;

    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_fold;
    logic             w_cnt_full;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_err_next;

    // Ready depends on state alone so the upstream never sees a loop through in_valid.
    assign w_in_ready = (r_state != S_OUT);
    assign w_accept   = in_valid && w_in_ready;

    // acc is always zero in S_IDLE (cleared on reset and on result hand-off),
    // so the same fold serves the first word and every later one.
    xor_word_fold #(
        .WIDTH (WIDTH)
    ) u_fold (
        .a (r_acc),
        .b (in_data),
        .f (w_fold)
    );

    // Once the count sits at MAX_WORDS any further word is overlength:
    // the count holds and the error latches for the rest of the frame.
    assign w_cnt_full = (r_cnt == MAX_CNT);
    assign w_cnt_next = w_cnt_full ? r_cnt : (r_cnt + CNT_W'(1));
    assign w_err_next = r_err | w_cnt_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_err          <= 1'b0;
            r_out_checksum <= '0;
            r_out_count    <= '0;
            r_out_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACC: begin
                    if (w_accept) begin
                        r_acc <= w_fold;
                        r_cnt <= w_cnt_next;
                        r_err <= w_err_next;
                        if (in_last) begin
                            // Result registers capture the folded value including the last word.
                            r_state        <= S_OUT;
                            r_out_checksum <= w_fold;
                            r_out_count    <= w_cnt_next;
                            r_out_err      <= w_err_next;
                        end else begin
                            r_state <= S_ACC;
                        end
                    end
                end
                S_OUT: begin
                    // Outputs keep their values after hand-off; only the frame state clears.
                    if (out_ready) begin
                        r_state <= S_IDLE;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = (r_state == S_OUT);
    assign out_checksum = r_out_checksum;
    assign out_count    = r_out_count;
    assign out_err      = r_out_err;

endmodule

// File: tb/tb_xor_frame_checksum.sv
// tb/tb_xor_frame_checksum.sv - directed self-checking bench for xor_frame_checksum
module tb_xor_frame_checksum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_err;
    logic [15:0] a_out_checksum;
    logic [8:0]  a_out_count;

    logic        b_in_ready, b_out_valid, b_out_err;
    logic [15:0] b_out_checksum;
    logic [2:0]  b_out_count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    xor_frame_checksum u_dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (a_in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (a_out_valid),
        .out_ready    (out_ready),
        .out_checksum (a_out_checksum),
        .out_count    (a_out_count),
        .out_err      (a_out_err)
    );

    xor_frame_checksum #(
        .WIDTH     (16),
        .MAX_WORDS (4),
        .CNT_W     (3)
    ) u_dut4 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (b_in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (b_out_valid),
        .out_ready    (out_ready),
        .out_checksum (b_out_checksum),
        .out_count    (b_out_count),
        .out_err      (b_out_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one word at the negedge; it is accepted on the following posedge.
    task automatic send(input logic [15:0] d, input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_checksum", 32'(a_out_checksum), 32'd0);
        chk("rst_count", 32'(a_out_count), 32'd0);
        chk("rst_err", 32'(a_out_err), 32'd0);

        // 1: three-word frame
        send(16'haaaa, 1'b0);
        @(negedge clk);
        chk("t1_no_early_valid", 32'(a_out_valid), 32'd0);
        send(16'h00ff, 1'b0);
        send(16'h0f0f, 1'b1);
        @(negedge clk);
        chk("t1_valid", 32'(a_out_valid), 32'd1);
        chk("t1_checksum", 32'(a_out_checksum), 32'ha55a);
        chk("t1_count", 32'(a_out_count), 32'd3);
        chk("t1_err", 32'(a_out_err), 32'd0);
        drain();

        // 2: single-word frame
        send(16'h9ab0, 1'b1);
        @(negedge clk);
        chk("t2_valid", 32'(a_out_valid), 32'd1);
        chk("t2_checksum", 32'(a_out_checksum), 32'h9ab0);
        chk("t2_count", 32'(a_out_count), 32'd1);
        drain();

        // 3: backpressure on the result
        send(16'h0f0f, 1'b0);
        send(16'h3333, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("t3_hold_valid_%0d", i), 32'(a_out_valid), 32'd1);
            chk($sformatf("t3_hold_checksum_%0d", i), 32'(a_out_checksum), 32'h3c3c);
            chk($sformatf("t3_hold_in_ready_%0d", i), 32'(a_in_ready), 32'd0);
        end
        drain();
        @(negedge clk);
        chk("t3_release_valid", 32'(a_out_valid), 32'd0);
        chk("t3_release_in_ready", 32'(a_in_ready), 32'd1);

        // 4: reset mid-frame discards the partial frame
        send(16'hffff, 1'b0);
        send(16'h1111, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t4_rst_valid", 32'(a_out_valid), 32'd0);
        chk("t4_rst_checksum", 32'(a_out_checksum), 32'd0);
        chk("t4_rst_count", 32'(a_out_count), 32'd0);
        chk("t4_rst_err", 32'(a_out_err), 32'd0);
        chk("t4_rst_in_ready", 32'(a_in_ready), 32'd1);
        send(16'h1234, 1'b1);
        @(negedge clk);
        chk("t4_valid", 32'(a_out_valid), 32'd1);
        chk("t4_checksum", 32'(a_out_checksum), 32'h1234);
        chk("t4_count", 32'(a_out_count), 32'd1);
        drain();

        // 5: overlength frame on the MAX_WORDS=4 instance
        for (int i = 0; i < 5; i++) send(16'h0001, (i == 4));
        @(negedge clk);
        chk("t5_valid", 32'(b_out_valid), 32'd1);
        chk("t5_checksum", 32'(b_out_checksum), 32'h0001);
        chk("t5_count", 32'(b_out_count), 32'd4);
        chk("t5_err", 32'(b_out_err), 32'd1);
        chk("t5_default_count", 32'(a_out_count), 32'd5);
        chk("t5_default_err", 32'(a_out_err), 32'd0);
        drain();
        send(16'hbeef, 1'b1);
        @(negedge clk);
        chk("t5_next_valid", 32'(b_out_valid), 32'd1);
        chk("t5_next_err", 32'(b_out_err), 32'd0);
        chk("t5_next_count", 32'(b_out_count), 32'd1);
        chk("t5_next_checksum", 32'(b_out_checksum), 32'hbeef);
        drain();

        // 6: idle cycle inside a frame
        send(16'h00ff, 1'b0);
        @(negedge clk);
        chk("t6_idle_valid", 32'(a_out_valid), 32'd0);
        send(16'h12ff, 1'b1);
        @(negedge clk);
        chk("t6_valid", 32'(a_out_valid), 32'd1);
        chk("t6_checksum", 32'(a_out_checksum), 32'h1200);
        chk("t6_count", 32'(a_out_count), 32'd2);
        chk("t6_err", 32'(a_out_err), 32'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
